// File: rtl/aes_round_ctrl.sv
// ============================================================================
// Module   : aes_round_ctrl
// Purpose  : Round sequencer for the iterative AES-128 datapath: mux select,
//            state write enable, key-schedule pacing and round constant.
// Options  : AES_CTRL_ABORT_EN adds a synchronous abort input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_round_ctrl #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
`ifdef AES_CTRL_ABORT_EN
  input  logic       abort,
`endif
  output logic [2:0] sel,
  output logic       state_we,
  output logic       key_load,
  output logic       key_step,
  output logic [7:0] rcon,
  output logic [3:0] round,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] c_LAST_ROUND = 4'(NUM_ROUNDS);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_SB   = 3'd2,
    ST_SR   = 3'd3,
    ST_MC   = 3'd4,
    ST_ARK  = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_round;
  logic [3:0] w_round_nxt;
  logic [7:0] r_rc;
  logic [7:0] w_rc_nxt;
  logic       w_last;

  // GF(2^8) doubling: the next round constant is xtime of the current one.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  assign w_last = (r_round == c_LAST_ROUND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_round <= 4'd0;
      r_rc    <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_round <= w_round_nxt;
      r_rc    <= w_rc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_round_nxt = r_round;
    w_rc_nxt    = r_rc;
    sel         = 3'd0;
    state_we    = 1'b0;
    key_load    = 1'b0;
    key_step    = 1'b0;
    rcon        = 8'h00;
    busy        = 1'b0;
    done        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_INIT;
        end
      end
      ST_INIT: begin
        sel         = 3'd0;
        state_we    = 1'b1;
        key_load    = 1'b1;
        busy        = 1'b1;
        w_round_nxt = 4'd1;
        w_rc_nxt    = 8'h01;
        w_state_nxt = ST_SB;
      end
      ST_SB: begin
        sel         = 3'd1;
        state_we    = 1'b1;
        key_step    = 1'b1;
        rcon        = r_rc;
        busy        = 1'b1;
        w_state_nxt = ST_SR;
      end
      ST_SR: begin
        sel         = 3'd2;
        state_we    = 1'b1;
        busy        = 1'b1;
        // The final round has no MixColumns.
        w_state_nxt = w_last ? ST_ARK : ST_MC;
      end
      ST_MC: begin
        sel         = 3'd3;
        state_we    = 1'b1;
        busy        = 1'b1;
        w_state_nxt = ST_ARK;
      end
      ST_ARK: begin
        sel      = 3'd4;
        state_we = 1'b1;
        busy     = 1'b1;
        if (w_last) begin
          w_round_nxt = 4'd0;
          w_state_nxt = ST_DONE;
        end else begin
          w_round_nxt = r_round + 4'd1;
          w_rc_nxt    = xtime(r_rc);
          w_state_nxt = ST_SB;
        end
      end
      ST_DONE: begin
        done        = 1'b1;
        w_round_nxt = 4'd0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_round_nxt = 4'd0;
        w_state_nxt = ST_IDLE;
      end
    endcase

`ifdef AES_CTRL_ABORT_EN
    if (abort && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
      w_round_nxt = 4'd0;
    end
`endif
  end

  assign round = r_round;

endmodule

`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
// ============================================================================
// Module   : tb_aes_round_ctrl
// Purpose  : Self-checking bench for aes_round_ctrl against a round-list model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_round_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
`ifdef AES_CTRL_ABORT_EN
  logic       abort = 1'b0;
`endif
  logic [2:0] sel;
  logic       state_we;
  logic       key_load;
  logic       key_step;
  logic [7:0] rcon;
  logic [3:0] round;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  aes_round_ctrl #(.NUM_ROUNDS(10)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
`ifdef AES_CTRL_ABORT_EN
    .abort    (abort),
`endif
    .sel      (sel),
    .state_we (state_we),
    .key_load (key_load),
    .key_step (key_step),
    .rcon     (rcon),
    .round    (round),
    .busy     (busy),
    .done     (done)
  );

  typedef struct packed {
    logic [2:0] sel;
    logic       we;
    logic       kl;
    logic       ks;
    logic [7:0] rcon;
    logic [3:0] round;
    logic       busy;
    logic       done;
  } outs_t;

  outs_t exp_q[$];

  function automatic outs_t observed();
    outs_t o;
    o = {sel, state_we, key_load, key_step, rcon, round, busy, done};
    return o;
  endfunction

  function automatic outs_t mk(int s, bit we, bit kl, bit ks, int rc, int r, bit b, bit d);
    outs_t o;
    o.sel   = s[2:0];
    o.we    = we;
    o.kl    = kl;
    o.ks    = ks;
    o.rcon  = rc[7:0];
    o.round = r[3:0];
    o.busy  = b;
    o.done  = d;
    return o;
  endfunction

  // Round constant as the (r-1)th power of x in GF(2^8), by repeated doubling.
  function automatic int rc_of(int r);
    int v = 1;
    for (int i = 1; i < r; i++) begin
      v = v * 2;
      if (v > 255) v = v ^ 'h11B;
    end
    return v;
  endfunction

  // One encryption as seen cycle by cycle from E+1 (INIT) to E+42 (IDLE).
  task automatic build_model();
    exp_q.delete();
    exp_q.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0));
    for (int r = 1; r <= 10; r++) begin
      exp_q.push_back(mk(1, 1, 0, 1, rc_of(r), r, 1, 0));
      exp_q.push_back(mk(2, 1, 0, 0, 0, r, 1, 0));
      if (r < 10) exp_q.push_back(mk(3, 1, 0, 0, 0, r, 1, 0));
      exp_q.push_back(mk(4, 1, 0, 0, 0, r, 1, 0));
    end
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic test_reset();
    outs_t act;
    rst_n = 1'b0;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    act = observed();
    n_tests++;
    if (act !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h expected=%h", act, outs_t'(0));
    end
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  // noise=1 toggles start randomly while busy and in DONE; it must be ignored.
  task automatic test_single_run(input bit noise, input string tag);
    outs_t act;
    int n_we = 0, n_ks = 0, n_kl = 0;
    repeat ($urandom_range(0, 4)) @(posedge clk);
    #1;
    start = 1'b1;
    for (int idx = 0; idx < 42; idx++) begin
      @(posedge clk);
      #1;
      act = observed();
      n_we += int'(act.we);
      n_ks += int'(act.ks);
      n_kl += int'(act.kl);
      n_tests++;
      if (act !== exp_q[idx]) begin
        n_fail++;
        $display("FAIL %s cycle E+%0d got sel=%0d we=%b kl=%b ks=%b rcon=%h round=%0d busy=%b done=%b expected sel=%0d we=%b kl=%b ks=%b rcon=%h round=%0d busy=%b done=%b",
                 tag, idx + 1, act.sel, act.we, act.kl, act.ks, act.rcon, act.round, act.busy, act.done,
                 exp_q[idx].sel, exp_q[idx].we, exp_q[idx].kl, exp_q[idx].ks, exp_q[idx].rcon,
                 exp_q[idx].round, exp_q[idx].busy, exp_q[idx].done);
      end
      start = (noise && idx < 41) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    n_tests++;
    if (n_we != 40 || n_ks != 10 || n_kl != 1) begin
      n_fail++;
      $display("FAIL %s_totals got we=%0d ks=%0d kl=%0d expected we=40 ks=10 kl=1", tag, n_we, n_ks, n_kl);
    end
  endtask

  task automatic test_back_to_back();
    outs_t act;
    int    n_done = 0;
    #1;
    start = 1'b1;
    for (int blk = 0; blk < 2; blk++) begin
      for (int idx = 0; idx < 42; idx++) begin
        @(posedge clk);
        #1;
        act = observed();
        n_done += int'(act.done);
        n_tests++;
        if (act !== exp_q[idx]) begin
          n_fail++;
          $display("FAIL back_to_back blk=%0d cycle E+%0d got=%h expected=%h", blk, idx + 1, act, exp_q[idx]);
        end
        if (blk == 1 && idx == 40) start = 1'b0;
      end
    end
    n_tests++;
    if (n_done != 2) begin
      n_fail++;
      $display("FAIL back_to_back_done_count got=%0d expected=2", n_done);
    end
  endtask

  task automatic test_async_reset();
    outs_t act;
    int    stop_idx = $urandom_range(17, 20);
    #1;
    start = 1'b1;
    for (int idx = 0; idx <= stop_idx; idx++) begin
      @(posedge clk);
      #1;
      act = observed();
      n_tests++;
      if (act !== exp_q[idx]) begin
        n_fail++;
        $display("FAIL pre_reset cycle E+%0d got=%h expected=%h", idx + 1, act, exp_q[idx]);
      end
      start = 1'b0;
    end
    #($urandom_range(1, 3));
    rst_n = 1'b0;
    #1;
    act = observed();
    n_tests++;
    if (act !== '0) begin
      n_fail++;
      $display("FAIL async_reset_immediate got=%h expected=%h", act, outs_t'(0));
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      act = observed();
      n_tests++;
      if (act !== '0) begin
        n_fail++;
        $display("FAIL post_reset_idle k=%0d got=%h expected=%h", k, act, outs_t'(0));
      end
    end
  endtask

`ifdef AES_CTRL_ABORT_EN
  task automatic test_abort();
    outs_t act;
    #1;
    start = 1'b1;
    // Round 3 MC falls in cycle E+12.
    for (int idx = 0; idx <= 11; idx++) begin
      @(posedge clk);
      #1;
      act = observed();
      n_tests++;
      if (act !== exp_q[idx]) begin
        n_fail++;
        $display("FAIL pre_abort cycle E+%0d got=%h expected=%h", idx + 1, act, exp_q[idx]);
      end
      start = 1'b0;
    end
    abort = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      abort = 1'b0;
      act = observed();
      n_tests++;
      if (act !== '0) begin
        n_fail++;
        $display("FAIL post_abort_idle k=%0d got=%h expected=%h", k, act, outs_t'(0));
      end
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    build_model();
    test_reset();
    test_single_run(1'b0, "single_run");
    test_single_run(1'b1, "start_ignored");
    test_back_to_back();
    repeat (3) @(posedge clk);
    test_async_reset();
    test_single_run(1'b0, "run_after_reset");
`ifdef AES_CTRL_ABORT_EN
    test_abort();
    test_single_run(1'b0, "run_after_abort");
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Round sequencer for the iterative AES-128 encryption datapath. It accepts a start request and steps a round counter through rounds 1–10. Each cycle it drives the 3-bit select of the 128-bit 5:1 state multiplexer and the state-register write enable, so the correct stage output is loaded into the state register. It also paces the key-schedule block with a step strobe and the round constant.

## Interface
- `NUM_ROUNDS`, default 10: number of cipher rounds; only 10 (AES-128) is supported.
- `clk  in  1`: single clock; all state updates on the rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `start  in  1`: begin one encryption; sampled only in IDLE.
- `abort  in  1`: present only with `AES_CTRL_ABORT_EN`; synchronous cancel.
- `sel  out  3`: state-mux select:
  - 0 = initial AddRoundKey (plaintext ^ key)
  - 1 = SubBytes
  - 2 = ShiftRows
  - 3 = MixColumns
  - 4 = AddRoundKey
- `state_we  out  1`: load the mux output into the state register this cycle.
- `key_load  out  1`: load the cipher key into the key register; high in INIT.
- `key_step  out  1`: advance the key schedule by one round this cycle.
- `rcon  out  8`: round constant accompanying `key_step`.
- `round  out  4`: current round number (0 in INIT, 1–10 in rounds).
- `busy  out  1`: high from INIT through the final AddRoundKey.
- `done  out  1`: one-cycle pulse; ciphertext is valid in the state register.

## Operation
- FSM states are IDLE, INIT, SB, SR, MC, ARK and DONE.
- IDLE:
  - All outputs are 0.
  - `start`=1 moves to INIT; otherwise the FSM stays in IDLE.
- INIT:
  - Outputs: sel=0, state_we=1, key_load=1, round=0.
  - Next state is SB with round=1.
- SB:
  - Outputs: sel=1, state_we=1, key_step=1, rcon=RC[round].
  - Next state is SR.
- SR:
  - Outputs: sel=2, state_we=1.
  - Next state is MC if round<10, else ARK.
- MC:
  - Outputs: sel=3, state_we=1.
  - Next state is ARK.
- ARK:
  - Outputs: sel=4, state_we=1.
  - If round<10, round increments and the next state is SB; otherwise the next state is DONE.
- DONE:
  - Outputs: done=1, busy=0.
  - Next state is IDLE.
- RC[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36 (hex).
  - Generated by xtime: doubling with 0x1B reduction when bit 7 is set.
  - Resets to 01 in INIT.
- `rcon` is 0 whenever `key_step`=0.
- `sel` is never driven to 5–7. In IDLE and DONE, sel=0 with state_we=0.
- `start` is ignored outside IDLE, including in DONE.
- `round` is 4 bits and never exceeds 10. It holds 0 in IDLE and DONE.

## Timing
- Reset values (`rst_n` low, any time): FSM in IDLE, round=0, rcon=0, all other outputs 0. Reset takes effect immediately, without waiting for a clock edge.
- Reset mid-operation abandons the encryption with no `done`. After `rst_n` deasserts, the first `start` begins a fresh encryption.
- Outputs are combinational functions of the registered FSM state and round counter. There is no input-to-output combinational path except through state.
- Latency, taking edge E as the edge that samples `start` in IDLE:
  - INIT occupies cycle E+1.
  - Rounds 1–9 occupy E+2..E+37, at 4 cycles each.
  - Round 10 (SB, SR, ARK) occupies E+38..E+40.
  - DONE is high in cycle E+41.
  - IDLE resumes in cycle E+42.
- Total: 40 `state_we` cycles, 10 `key_step` pulses, 1 `key_load` per encryption.
- Throughput: one block per 42 cycles when `start` is held high.

## Configuration
- Macro `AES_CTRL_ABORT_EN`.
- Defined:
  - The `abort` port exists.
  - `abort`=1 at a rising edge in any state except IDLE sends the FSM to IDLE with round=0.
  - No `done` pulse follows an abort.
  - `abort` takes priority over all other transitions, including DONE→IDLE. In that case the pulse already shown is kept and the FSM goes to IDLE.
- Undefined:
  - The `abort` port is absent.
  - Once started, an encryption always runs to DONE unless reset.

## Test plan
- Reset, then `start` for 1 cycle:
  - Check the sel sequence 0, then (1,2,3,4)×9, then 1,2,4.
  - Check state_we=1 for exactly 40 cycles and `done`=1 only in cycle E+41.
- Same run: `rcon` on the 10 `key_step` cycles must read 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36. `rcon`=0 on every other cycle.
- With the state mux, SubBytes/ShiftRows/MixColumns/AddRoundKey and key-expansion stages attached:
  - Inputs: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff.
  - Required state at `done`: 69c4e0d86a7b0430d8cdb78070b4c55a.
- `start` held high continuously:
  - `done` pulses at E+41, E+83 and so on.
  - `start` pulses while `busy` is high are ignored: no extra INIT cycles.
- `rst_n` driven low asynchronously mid-edge-interval during round 5:
  - All outputs read 0 immediately.
  - No `done` appears.
  - A new `start` yields a full 40-cycle run.
- With `AES_CTRL_ABORT_EN` defined:
  - `abort` asserted during round 3 MC returns to IDLE on that edge with no `done`.
  - A subsequent `start` produces correct `rcon` beginning at 01.
